// File: rtl/snax_gemm_c_serializer.sv
// snax_gemm_c_serializer
//   Splits each wide GEMM C result word into DataWidthOut-wide beats for the
//   C-write streamer, lowest slice first. A single holding register keeps the
//   word being serialized. The next word is accepted on the cycle its
//   predecessor's last beat is taken, so back-to-back words leave no bubble.
//
// Ports
//   clk_i, rst_ni         clock, async active-low reset
//   c_data_i/valid/ready  wide word input handshake
//   out_data_o/valid/rdy  narrow beat output handshake
//   clear_i               sync flush: drops the held word and zeroes the counters
//   busy_o                a word is held (state SEND)
//   word_cnt_o            wide words fully emitted since reset/clear (wraps)
//   stall_cnt_o           only with SNAX_GEMM_SER_PERF_EN: cycles with
//                         out_valid_o & !out_ready_i, saturating
//
// Configuration macro: SNAX_GEMM_SER_PERF_EN
module snax_gemm_c_serializer #(
    parameter int unsigned DataWidthC   = 2048,
    parameter int unsigned DataWidthOut = 512
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DataWidthC-1:0]   c_data_i,
    input  logic                    c_valid_i,
    output logic                    c_ready_o,
    output logic [DataWidthOut-1:0] out_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    input  logic                    clear_i,
    output logic                    busy_o,
    output logic [31:0]             word_cnt_o
`ifdef SNAX_GEMM_SER_PERF_EN
    ,
    output logic [31:0]             stall_cnt_o
`endif
);

    localparam int unsigned NumBeats = DataWidthC / DataWidthOut;
    localparam int unsigned BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(NumBeats - 1);

    if (DataWidthC % DataWidthOut != 0) begin : g_bad_width
        $error("DataWidthC must be a multiple of DataWidthOut");
    end

    typedef enum logic {IDLE, SEND} state_e;

    state_e                  state_q, state_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic [DataWidthC-1:0]   data_q;
    logic [31:0]             word_cnt_q;
    logic                    out_hs, last_hs, load;

    always_comb begin
        out_hs  = (state_q == SEND) & out_ready_i;
        last_hs = out_hs & (beat_q == LastBeat);
        // Ready never depends on c_valid_i; clear blocks any acceptance.
        c_ready_o = ~clear_i & ((state_q == IDLE) | last_hs);
        load      = c_valid_i & c_ready_o;
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (clear_i) begin
            state_d = IDLE;
            beat_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_d = SEND;
                        beat_d  = '0;
                    end
                end
                SEND: begin
                    if (last_hs) begin
                        // Refill straight from the input to avoid a bubble.
                        state_d = load ? SEND : IDLE;
                        beat_d  = '0;
                    end else if (out_hs) begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            data_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (load) data_q <= c_data_i;
            if (clear_i)      word_cnt_q <= '0;
            else if (last_hs) word_cnt_q <= word_cnt_q + 32'd1;
        end
    end

`ifdef SNAX_GEMM_SER_PERF_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (clear_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == SEND) && !out_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
    assign stall_cnt_o = stall_cnt_q;
`endif

    assign out_valid_o = (state_q == SEND);
    assign busy_o      = (state_q == SEND);
    assign word_cnt_o  = word_cnt_q;
    assign out_data_o  = data_q[int'(beat_q)*DataWidthOut +: DataWidthOut];

endmodule

// File: tb/tb_snax_gemm_c_serializer.sv
module tb_snax_gemm_c_serializer;

    localparam int WC = 2048;
    localparam int WO = 512;
    localparam int NB = WC / WO;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [WC-1:0] c_data_i;
    logic          c_valid_i;
    logic          c_ready_o;
    logic [WO-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic          clear_i;
    logic          busy_o;
    logic [31:0]   word_cnt_o;
`ifdef SNAX_GEMM_SER_PERF_EN
    logic [31:0]   stall_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    snax_gemm_c_serializer #(.DataWidthC(WC), .DataWidthOut(WO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .c_data_i(c_data_i), .c_valid_i(c_valid_i), .c_ready_o(c_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .clear_i(clear_i), .busy_o(busy_o), .word_cnt_o(word_cnt_o)
`ifdef SNAX_GEMM_SER_PERF_EN
        , .stall_cnt_o(stall_cnt_o)
`endif
    );

    function automatic logic [WC-1:0] rand_word();
        logic [WC-1:0] w;
        for (int i = 0; i < WC/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [WO-1:0] slice(input logic [WC-1:0] w, input int b);
        return w[b*WO +: WO];
    endfunction

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0; c_valid_i = 1'b0; c_data_i = '0;
        out_ready_i = 1'b1; clear_i = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        step();
    endtask

    // Hand one word in and drain all its beats with out_ready_i=1.
    task automatic send_word(input logic [WC-1:0] w);
        c_data_i = w; c_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        c_valid_i = 1'b0;
        for (int b = 0; b < NB; b++) begin
            #1;
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== slice(w, b)) begin
                failures++;
                $display("FAIL send_word beat %0d: valid=%b data=%h expected data=%h", b, out_valid_o, out_data_o, slice(w, b));
            end
            step();
        end
    endtask

    task automatic test_reset();
        logic [WC-1:0] w;
        reset_dut();
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || c_ready_o !== 1'b1 || word_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: valid=%b busy=%b ready=%b cnt=%0d expected 0 0 1 0", out_valid_o, busy_o, c_ready_o, word_cnt_o);
        end
        send_word(rand_word());
        w = rand_word();
        c_data_i = w; c_valid_i = 1'b1;
        step();
        c_valid_i = 1'b0;
        step(); step();   // beats 0 and 1 taken, beat 2 now showing
        #1;
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== slice(w, 2) || word_cnt_o !== 32'd1) begin
            failures++;
            $display("FAIL reset_pre: valid=%b cnt=%0d data=%h expected 1 1 %h", out_valid_o, word_cnt_o, out_data_o, slice(w, 2));
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || c_ready_o !== 1'b1 || word_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_async: valid=%b busy=%b ready=%b cnt=%0d expected 0 0 1 0", out_valid_o, busy_o, c_ready_o, word_cnt_o);
        end
        step();
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || c_ready_o !== 1'b1 || word_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_edge: valid=%b busy=%b ready=%b cnt=%0d expected 0 0 1 0", out_valid_o, busy_o, c_ready_o, word_cnt_o);
        end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [WC-1:0] w;
        reset_dut();
        w = {512'hD, 512'hC, 512'hB, 512'hA};
        c_data_i = w; c_valid_i = 1'b1; out_ready_i = 1'b1;
        #1;
        checks++;
        if (c_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: ready=%b valid=%b expected 1 0", c_ready_o, out_valid_o);
        end
        step();
        c_valid_i = 1'b0;
        for (int b = 0; b < NB; b++) begin
            #1;
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== slice(w, b) || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL single_beat%0d: valid=%b busy=%b data=%h expected %h", b, out_valid_o, busy_o, out_data_o, slice(w, b));
            end
            step();
        end
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || word_cnt_o !== 32'd1) begin
            failures++;
            $display("FAIL single_done: valid=%b busy=%b cnt=%0d expected 0 0 1", out_valid_o, busy_o, word_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [WC-1:0] w [3];
        logic          exp_rdy;
        reset_dut();
        for (int i = 0; i < 3; i++) w[i] = rand_word();
        out_ready_i = 1'b1;
        // Cycle 0 accepts word 0; cycles 1..12 show the 12 beats.
        for (int k = 0; k <= 3*NB; k++) begin
            c_valid_i = (k <= 2*NB);
            c_data_i  = w[(k + NB - 1) / NB < 3 ? (k + NB - 1) / NB : 2];
            #1;
            exp_rdy = (k % NB == 0);
            checks++;
            if (c_ready_o !== exp_rdy) begin
                failures++;
                $display("FAIL b2b_ready k=%0d: got %b expected %b", k, c_ready_o, exp_rdy);
            end
            if (k > 0) begin
                checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== slice(w[(k-1)/NB], (k-1) % NB)) begin
                    failures++;
                    $display("FAIL b2b_beat k=%0d: valid=%b data=%h expected %h", k, out_valid_o, out_data_o, slice(w[(k-1)/NB], (k-1) % NB));
                end
            end
            step();
        end
        c_valid_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || word_cnt_o !== 32'd3) begin
            failures++;
            $display("FAIL b2b_done: valid=%b cnt=%0d expected 0 3", out_valid_o, word_cnt_o);
        end
    endtask

    task automatic test_backpressure();
        logic [WC-1:0] w;
        reset_dut();
        w = rand_word();
        c_data_i = w; c_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        c_valid_i = 1'b1;   // a waiting word must not be taken during the stall
        c_data_i = rand_word();
        step();             // beat 0 taken
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== slice(w, 1) || c_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold %0d: valid=%b ready=%b data=%h expected %h", i, out_valid_o, c_ready_o, out_data_o, slice(w, 1));
            end
            step();
        end
        c_valid_i = 1'b0;
        out_ready_i = 1'b1;
`ifdef SNAX_GEMM_SER_PERF_EN
        #1;
        checks++;
        if (stall_cnt_o !== 32'd5) begin
            failures++;
            $display("FAIL bp_stall_cnt: got %0d expected 5", stall_cnt_o);
        end
`endif
        for (int b = 1; b < NB; b++) begin
            #1;
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== slice(w, b)) begin
                failures++;
                $display("FAIL bp_release beat%0d: valid=%b data=%h expected %h", b, out_valid_o, out_data_o, slice(w, b));
            end
            step();
        end
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || word_cnt_o !== 32'd1) begin
            failures++;
            $display("FAIL bp_done: valid=%b cnt=%0d expected 0 1", out_valid_o, word_cnt_o);
        end
    endtask

    task automatic test_clear();
        logic [WC-1:0] w, w2;
        reset_dut();
        send_word(rand_word());
        w = rand_word();
        c_data_i = w; c_valid_i = 1'b1;
        step();
        c_valid_i = 1'b0;
        step(); step();     // beat 2 showing
        clear_i = 1'b1; c_valid_i = 1'b1; c_data_i = rand_word();
        #1;
        checks++;
        if (c_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL clear_ready: got %b expected 0", c_ready_o);
        end
        step();
        clear_i = 1'b0; c_valid_i = 1'b0;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || word_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL clear_state: valid=%b busy=%b cnt=%0d expected 0 0 0", out_valid_o, busy_o, word_cnt_o);
        end
        w2 = rand_word();
        send_word(w2);
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || word_cnt_o !== 32'd1) begin
            failures++;
            $display("FAIL clear_after: valid=%b cnt=%0d expected 0 1", out_valid_o, word_cnt_o);
        end
    endtask

    task automatic test_wrap();
        reset_dut();
        force dut.word_cnt_q = 32'hFFFF_FFFF;
        step();
        release dut.word_cnt_q;
        #1;
        checks++;
        if (word_cnt_o !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_preset: got %h expected ffffffff", word_cnt_o);
        end
        send_word(rand_word());
        #1;
        checks++;
        if (word_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL wrap: got %h expected 0", word_cnt_o);
        end
    endtask

    // Random traffic against a beat-queue reference: the queue holds the beats
    // still owed for the held word.
    task automatic test_random();
        logic [WO-1:0] q [$];
        logic [WC-1:0] w;
        logic          exp_rdy, exp_vld;
        logic [31:0]   cnt;
        logic [31:0]   stall;
        reset_dut();
        cnt = 0; stall = 0;
        for (int k = 0; k < 400; k++) begin
            w = rand_word();
            c_data_i    = w;
            c_valid_i   = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            clear_i     = ($urandom_range(0, 39) == 0);
            #1;
            exp_vld = (q.size() > 0);
            exp_rdy = !clear_i && (q.size() == 0 || (q.size() == 1 && out_ready_i));
            checks++;
            if (out_valid_o !== exp_vld || busy_o !== exp_vld || c_ready_o !== exp_rdy || word_cnt_o !== cnt) begin
                failures++;
                $display("FAIL rand k=%0d: valid=%b busy=%b ready=%b cnt=%0d expected %b %b %b %0d", k, out_valid_o, busy_o, c_ready_o, word_cnt_o, exp_vld, exp_vld, exp_rdy, cnt);
            end
            if (exp_vld) begin
                checks++;
                if (out_data_o !== q[0]) begin
                    failures++;
                    $display("FAIL rand_data k=%0d: got %h expected %h", k, out_data_o, q[0]);
                end
            end
`ifdef SNAX_GEMM_SER_PERF_EN
            checks++;
            if (stall_cnt_o !== stall) begin
                failures++;
                $display("FAIL rand_stall k=%0d: got %0d expected %0d", k, stall_cnt_o, stall);
            end
`endif
            if (clear_i) begin
                q.delete();
                cnt = 0;
                stall = 0;
            end else begin
                if (exp_vld && !out_ready_i) stall++;
                if (exp_vld && out_ready_i) begin
                    void'(q.pop_front());
                    if (q.size() == 0) cnt++;
                end
                if (c_valid_i && exp_rdy)
                    for (int b = 0; b < NB; b++) q.push_back(slice(w, b));
            end
            step();
        end
        clear_i = 1'b0; c_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
